axi_ddr_frame_reader: RTL
=========================

AXI_DDR_FRAME_READER -- requirements
Module: axi_ddr_frame_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, meaning AXI data width in bits (power of 2, at least 32).
REQ-002 SHALL have parameter MAX_BEATS, default 8, meaning maximum beats per frame (1..256).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-004 SHALL have parameter ID_WIDTH, default 4, meaning ARID/RID width.
REQ-005 SHALL have parameter AXI_ID, default 0, meaning constant ARID value.
REQ-006 SHALL have the following ports, one per line: name, direction, width, meaning.
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- cfg_base  in  ADDR_WIDTH  region base byte address; DATA_WIDTH/8-aligned.
- cfg_frames  in  16  frames in region.
- cfg_beats  in  8  beats per frame.
- start  in  1  launch request; sampled in IDLE only.
- cont  in  1  continuous mode; sampled with start.
- stop  in  1  clears latched continuous mode.
- busy  out  1  high whenever state is not IDLE.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accept.
- out_data  out  MAX_BEATS*DATA_WIDTH  packed frame.
- out_wrap  out  1  this frame is the last frame of the region.
- err_len  out  1  sticky RLAST/beat-count mismatch.
- err_resp  out  1  sticky response/ID error.
- M_AXI_ar*  AXI4 AR master channel: araddr, arburst, arcache, arid, arlen, arlock, arprot, arqos, arsize, arvalid out; arready in.
- M_AXI_r*  AXI4 R master channel: rid, rdata, rlast, rresp, rvalid in; rready out.

Function
REQ-007 SHALL implement the states IDLE, AR, RECV and HOLD, with the following transitions:
- IDLE->AR on start with a legal config.
- AR->RECV on arvalid&arready.
- RECV->HOLD on the accepted beat with rlast.
- HOLD->AR on out_valid&out_ready when continuous mode is latched.
- HOLD->IDLE on out_valid&out_ready otherwise.
REQ-008 SHALL define a legal config as 1<=cfg_beats<=MAX_BEATS and cfg_frames>=1; SHALL ignore start otherwise and remain in IDLE.
REQ-009 SHALL latch cfg_base, cfg_frames, cfg_beats and cont on accepted start, clear err_len and err_resp, and set frame index to 0.
REQ-010 SHALL assert arvalid the cycle after entry to AR and hold arvalid and all AR fields stable until arready.
REQ-011 SHALL drive the AR fields as follows:
- araddr = base + idx*beats*(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH.
- arlen = beats-1.
- arsize = log2(DATA_WIDTH/8).
- arburst = INCR.
- arcache = 0011.
- arid = AXI_ID.
- arlock, arprot and arqos = 0.
REQ-012 SHALL assert rready only in RECV.
REQ-013 SHALL write beat k of a frame into out_data[(MAX_BEATS-1-k)*DATA_WIDTH +: DATA_WIDTH]; SHALL zero all unused lower slots at frame start.
REQ-014 SHALL ignore any beat with k>=beats (data dropped) and set err_len.
REQ-015 SHALL set err_len if rlast arrives at k!=beats-1; SHALL end the frame on rlast in all cases.
REQ-016 SHALL assert out_valid the cycle after the rlast beat and hold out_valid, out_data and out_wrap stable until out_ready; SHALL not issue a new AR before the handshake.
REQ-017 SHALL set out_wrap when idx==frames-1; after that frame, idx SHALL return to 0, otherwise idx SHALL increment.
REQ-018 SHALL clear the latched cont on stop in any state; the frame in flight SHALL complete and be delivered; stop together with start SHALL latch cont=0.

Reset
REQ-019 SHALL, on ARESETN low, asynchronously and immediately clear state to IDLE and clear busy, out_valid, out_data, out_wrap, err_len, err_resp, arvalid, araddr, arlen and rready; arsize/arburst/arcache SHALL take their REQ-011 constants and arid SHALL be AXI_ID.
REQ-020 SHALL, on reset mid-burst, drop all outstanding beats; no recovery of the AXI transaction is required.

Configuration
REQ-021 SHALL compile the response check only when macro AXI_DDR_RD_RESP_CHECK_EN is defined.
- With the macro: any accepted beat with rresp!=00 or rid!=AXI_ID sets err_resp; the data is still stored.
- Without the macro: err_resp SHALL be constant 0 and rresp/rid SHALL be unused.

Verification
REQ-022 SHALL cover single frame: base=0x1000, beats=5, frames=4, cont=0, start -> one AR with araddr=0x1000, arlen=4; out_data slots 7..3 hold beats 0..4, slots 2..0 zero; out_valid one cycle after rlast; busy falls after out_ready.
REQ-023 SHALL cover continuous wrap: beats=2, frames=3, cont=1 -> araddr 0x0,0x40,0x80,0x0,...; out_wrap set on the third frame only; stop mid-frame -> that frame delivered, then IDLE.
REQ-024 SHALL cover backpressure: out_ready low for 20 cycles -> out_valid and out_data stable, no AR issued; AR issued the cycle after out_ready.
REQ-025 SHALL cover errors: rlast on beat 2 of 5 -> err_len=1 and frame delivered; with macro, rresp=10 on one beat -> err_resp=1; without macro -> err_resp=0.
REQ-026 SHALL cover illegal config and reset: cfg_beats=0 or cfg_beats=9 (MAX_BEATS=8) -> start ignored, busy stays 0; ARESETN low during RECV -> rready=0 and state IDLE with no clock edge.

Source files
------------

// File: rtl/axi_ddr_frame_reader_if.sv
// AXI4 read-address and read-data channels used by the DDR frame reader.
interface axi_ddr_frame_reader_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic                  arlock;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic [2:0]            arsize;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arburst, arcache, arid, arlen,
        output arlock, arprot, arqos, arsize, arvalid,
        input  arready,
        input  rid, rdata, rlast, rresp, rvalid,
        output rready
    );

    modport slave (
        input  araddr, arburst, arcache, arid, arlen,
        input  arlock, arprot, arqos, arsize, arvalid,
        output arready,
        output rid, rdata, rlast, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_ddr_frame_reader.sv
// AXI4 read master fetching fixed-size frames from a DDR ring into a wide register.
// Define AXI_DDR_RD_RESP_CHECK_EN to flag bad rresp/rid beats on err_resp.
module axi_ddr_frame_reader #(
    parameter int DATA_WIDTH = 256,
    parameter int MAX_BEATS  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [ADDR_WIDTH-1:0]           cfg_base,
    input  logic [15:0]                     cfg_frames,
    input  logic [7:0]                      cfg_beats,
    input  logic                            start,
    input  logic                            cont,
    input  logic                            stop,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_BEATS*DATA_WIDTH-1:0] out_data,
    output logic                            out_wrap,
    output logic                            err_len,
    output logic                            err_resp,
    axi_ddr_frame_reader_if.master          m_axi
);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, AR, RECV, HOLD} state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0]           frames_q;
    logic [15:0]           idx_q;
    logic [7:0]            beats_q;
    logic [7:0]            arlen_q;
    logic                  cont_q;
    logic [8:0]            beat_q;
    logic                  wrap_q;

    logic                  cfg_ok;
    logic                  start_ok;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  out_hs;
    logic                  last_frame;
    logic                  beat_in_range;
    logic [23:0]           frame_beats;
    logic [ADDR_WIDTH-1:0] frame_off;

    assign cfg_ok = (cfg_beats != 8'd0)
                 && ({1'b0, cfg_beats} <= 9'(MAX_BEATS))
                 && (cfg_frames != 16'd0);

    assign start_ok      = (state_q == IDLE) && start && cfg_ok;
    assign ar_hs         = m_axi.arvalid && m_axi.arready;
    assign r_hs          = m_axi.rvalid && m_axi.rready;
    assign out_hs        = out_valid && out_ready;
    assign last_frame    = (idx_q == frames_q - 16'd1);
    assign beat_in_range = (beat_q < {1'b0, beats_q});

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = AR;
            AR:   if (ar_hs) state_d = RECV;
            RECV: if (r_hs && m_axi.rlast) state_d = HOLD;
            HOLD: if (out_hs) state_d = (cont_q && !stop) ? AR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign out_valid    = (state_q == HOLD);
    assign m_axi.arvalid = (state_q == AR);
    assign m_axi.rready  = (state_q == RECV);
    assign out_wrap     = wrap_q;

    // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
    assign frame_beats = 24'(idx_q) * 24'(beats_q);
    assign frame_off   = ADDR_WIDTH'(frame_beats) << SHIFT;

    assign m_axi.araddr  = base_q + frame_off;
    assign m_axi.arlen   = arlen_q;
    assign m_axi.arsize  = 3'(SHIFT);
    assign m_axi.arburst = 2'b01;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arid    = ID_WIDTH'(AXI_ID);
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arqos   = 4'b0000;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            base_q   <= '0;
            frames_q <= '0;
            beats_q  <= '0;
            arlen_q  <= '0;
            cont_q   <= 1'b0;
            idx_q    <= '0;
            beat_q   <= '0;
            wrap_q   <= 1'b0;
            out_data <= '0;
            err_len  <= 1'b0;
        end else begin
            if (stop) cont_q <= 1'b0;
            if (start_ok) begin
                base_q   <= cfg_base;
                frames_q <= cfg_frames;
                beats_q  <= cfg_beats;
                arlen_q  <= cfg_beats - 8'd1;
                cont_q   <= cont && !stop;
                idx_q    <= '0;
                err_len  <= 1'b0;
            end
            // The previous frame has been handed off; start from a clean slate.
            if (ar_hs) begin
                out_data <= '0;
                beat_q   <= '0;
            end
            if (r_hs) begin
                for (int i = 0; i < MAX_BEATS; i++) begin
                    if (beat_in_range && beat_q == 9'(i))
                        out_data[(MAX_BEATS-1-i)*DATA_WIDTH +: DATA_WIDTH] <= m_axi.rdata;
                end
                if (!beat_in_range ||
                    (m_axi.rlast && beat_q != {1'b0, beats_q} - 9'd1))
                    err_len <= 1'b1;
                if (beat_q != '1) beat_q <= beat_q + 9'd1;
                if (m_axi.rlast) wrap_q <= last_frame;
            end
            if (out_hs) idx_q <= wrap_q ? '0 : idx_q + 16'd1;
        end
    end

`ifdef AXI_DDR_RD_RESP_CHECK_EN
    logic err_resp_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            err_resp_q <= 1'b0;
        else if (start_ok)
            err_resp_q <= 1'b0;
        else if (r_hs && (m_axi.rresp != 2'b00 ||
                          m_axi.rid != ID_WIDTH'(AXI_ID)))
            err_resp_q <= 1'b1;
    end

    assign err_resp = err_resp_q;
`else
    logic unused_resp;

    assign unused_resp = ^{m_axi.rresp, m_axi.rid};
    assign err_resp    = 1'b0;
`endif

endmodule
